// File: rtl/adc_uart_streamer_pkg.sv
// adc_uart_streamer_pkg: FSM state types, frame markers and sample-to-byte formatting
package adc_uart_streamer_pkg;
  localparam logic FRAME_HI = 1'b1;
  localparam logic FRAME_LO = 1'b0;
  typedef enum logic {S_IDLE, S_CONV} adc_state_t;
  typedef enum logic [2:0] {T_IDLE, T_BUSY0_L, T_BUSY0_H, T_HI, T_BUSY1_L, T_BUSY1_H} tx_state_t;
  function automatic logic [7:0] hi_byte(input logic [9:0] d);
    return {FRAME_HI, 2'b00, d[9:5]};
  endfunction
  function automatic logic [7:0] lo_byte(input logic [9:0] d);
    return {FRAME_LO, 2'b00, d[4:0]};
  endfunction
endpackage

// File: rtl/adc_uart_streamer_sample_fifo.sv
// adc_uart_streamer_sample_fifo: show-ahead sample FIFO with wrap-bit pointers; push on full succeeds only alongside a pop
module adc_uart_streamer_sample_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/adc_uart_streamer.sv
// adc_uart_streamer: paces mcp3002 conversions, buffers samples and streams each as a framed byte pair to uart_tx
module adc_uart_streamer import adc_uart_streamer_pkg::*; #(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_RATE = 5_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADC_BITS    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stream_en,
  output logic                adc_enable,
  input  logic [ADC_BITS-1:0] adc_data,
  input  logic                adc_available,
  output logic [7:0]          tx_data,
  output logic                tx_enable,
  input  logic                tx_available,
  output logic                overrun,
  output logic                miss,
  output logic [7:0]          drop_count
);
  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int TW = $clog2(SAMPLE_DIV);
  logic [TW-1:0] count;
  logic tick, avail_prev, rise, push, pop, full, empty, drop;
  logic [ADC_BITS-1:0] dout, sample;
  adc_state_t adc_state, adc_next;
  tx_state_t tx_state, tx_next;
  assign tick = stream_en && count == TW'(SAMPLE_DIV - 1);
  assign rise = adc_available && !avail_prev;
  assign adc_enable = adc_state == S_CONV;
  assign drop = push && full && !pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (tick || !stream_en) ? '0 : count + TW'(1);
  always_comb begin
    adc_next = adc_state == S_IDLE ? (tick ? S_CONV : S_IDLE) : (rise ? S_IDLE : S_CONV);
    push = adc_state == S_CONV && rise;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      adc_state <= S_IDLE;
      avail_prev <= 1'b0;
      miss <= 1'b0;
      overrun <= 1'b0;
      drop_count <= '0;
    end else begin
      adc_state <= adc_next;
      avail_prev <= adc_available;
      miss <= miss || (tick && adc_state == S_CONV);
      overrun <= overrun || drop;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  adc_uart_streamer_sample_fifo #(.WIDTH(ADC_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (adc_data),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    tx_next = tx_state;
    pop = 1'b0;
    case (tx_state)
      T_IDLE: if (!empty && tx_available) begin
        pop = 1'b1;
        tx_next = T_BUSY0_L;
      end
      T_BUSY0_L: tx_next = tx_available ? T_BUSY0_L : T_BUSY0_H;
      T_BUSY0_H: tx_next = tx_available ? T_HI : T_BUSY0_H;
      T_HI:      tx_next = T_BUSY1_L;
      T_BUSY1_L: tx_next = tx_available ? T_BUSY1_L : T_BUSY1_H;
      T_BUSY1_H: tx_next = tx_available ? T_IDLE : T_BUSY1_H;
      default:   tx_next = T_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= T_IDLE;
      sample <= '0;
      tx_enable <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_state <= tx_next;
      sample <= pop ? dout : sample;
      tx_enable <= pop || tx_state == T_HI;
      tx_data <= pop ? hi_byte(dout) : tx_state == T_HI ? lo_byte(sample) : tx_data;
    end
endmodule

// File: tb/tb_adc_uart_streamer.sv
// tb_adc_uart_streamer: scoreboard bench with behavioural mcp3002 and uart_tx models
module tb_adc_uart_streamer;
  logic clk = 1'b0, rst_n = 1'b0, stream_en = 1'b0;
  logic adc_enable, adc_available, tx_enable, tx_available, overrun, miss;
  logic [9:0] adc_data;
  logic [7:0] tx_data, drop_count;
  int tests = 0, failed = 0;
  int adc_lat = 3, uart_lat = 4;
  logic stall = 1'b0, uart_hold = 1'b0, fix_en = 1'b0;
  logic [9:0] fix_val = '0, adc_val = 10'h13C;
  int acnt = 0, conv_n = 0, cyc = 0;
  logic [9:0] adc_hist [1024];
  int conv_t [1024];
  logic tx_busy = 1'b0, te_prev = 1'b0;
  int ucnt = 0, rx_n = 0, te_double = 0;
  logic [7:0] rx_hist [1024];
  logic [7:0] exp_q [$];
  int rx_base = 0, cv_base = 0, td_base = 0;

  adc_uart_streamer #(.CLK_FREQ(100), .SAMPLE_RATE(10), .FIFO_DEPTH(4), .ADC_BITS(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stream_en     (stream_en),
    .adc_enable    (adc_enable),
    .adc_data      (adc_data),
    .adc_available (adc_available),
    .tx_data       (tx_data),
    .tx_enable     (tx_enable),
    .tx_available  (tx_available),
    .overrun       (overrun),
    .miss          (miss),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      adc_available <= 1'b0;
      adc_data <= '0;
      acnt <= 0;
    end else if (adc_available) begin
      if (!adc_enable) adc_available <= 1'b0;
    end else if (adc_enable) begin
      if (acnt < adc_lat - 1) acnt <= acnt + 1;
      else if (!stall) begin
        adc_available <= 1'b1;
        adc_data <= fix_en ? fix_val : adc_val;
        adc_hist[conv_n[9:0]] <= fix_en ? fix_val : adc_val;
        conv_t[conv_n[9:0]] <= cyc;
        conv_n <= conv_n + 1;
        adc_val <= adc_val + 10'h05B;
        acnt <= 0;
      end
    end

  assign tx_available = !tx_busy && !uart_hold;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_busy <= 1'b0;
      ucnt <= 0;
      te_prev <= 1'b0;
    end else begin
      te_prev <= tx_enable;
      if (tx_enable && te_prev) te_double <= te_double + 1;
      if (tx_enable) begin
        rx_hist[rx_n[9:0]] <= tx_data;
        rx_n <= rx_n + 1;
        tx_busy <= 1'b1;
        ucnt <= 0;
      end else if (tx_busy) begin
        if (ucnt >= uart_lat - 1) tx_busy <= 1'b0;
        else ucnt <= ucnt + 1;
      end
    end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stream_en = 1'b0; uart_hold = 1'b0; stall = 1'b0; fix_en = 1'b0;
    adc_lat = 3; uart_lat = 4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rx_base = rx_n; cv_base = conv_n; td_base = te_double;
  endtask

  task automatic expect_sample(input logic [9:0] d);
    exp_q.push_back({1'b1, 2'b00, d[9:5]});
    exp_q.push_back({3'b000, d[4:0]});
  endtask

  task automatic wait_conv(input int n, input int maxc);
    for (int i = 0; i < maxc && conv_n - cv_base < n; i++) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int maxc);
    for (int i = 0; i < maxc && rx_n - rx_base < n; i++) @(negedge clk);
  endtask

  task automatic wait_adc_idle(input int maxc);
    for (int i = 0; i < maxc && (adc_enable || adc_available); i++) @(negedge clk);
  endtask

  task automatic wait_enable(input logic lvl, input int maxc);
    for (int i = 0; i < maxc && adc_enable !== lvl; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (adc_enable !== 1'b0) begin failed++; $display("FAIL reset_adc_enable: got %b want 0", adc_enable); end
    tests++; if (tx_enable !== 1'b0) begin failed++; $display("FAIL reset_tx_enable: got %b want 0", tx_enable); end
    tests++; if (tx_data !== 8'h00) begin failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (miss !== 1'b0) begin failed++; $display("FAIL reset_miss: got %b want 0", miss); end
    tests++; if (drop_count !== 8'h00) begin failed++; $display("FAIL reset_drop_count: got %h want 00", drop_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int k, n;
    do_reset();
    fix_en = 1'b1; fix_val = 10'h2A5; stream_en = 1'b1;
    repeat (9) @(negedge clk);
    tests++; if (adc_enable !== 1'b0) begin failed++; $display("FAIL basic_enable_early: got %b want 0", adc_enable); end
    @(negedge clk);
    tests++; if (adc_enable !== 1'b1) begin failed++; $display("FAIL basic_enable_tick: got %b want 1", adc_enable); end
    wait_conv(1, 50);
    stream_en = 1'b0;
    exp_q.push_back(8'h95);
    exp_q.push_back(8'h05);
    wait_rx(2, 100);
    repeat (20) @(negedge clk);
    n = exp_q.size();
    tests++; if (rx_n - rx_base !== n) begin failed++; $display("FAIL basic_byte_count: got %0d want %0d", rx_n - rx_base, n); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL basic_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
    tests++; if (te_double - td_base !== 0) begin failed++; $display("FAIL basic_tx_enable_width: got %0d long pulses want 0", te_double - td_base); end
  endtask

  task automatic test_miss();
    int k, n;
    do_reset();
    adc_lat = 15; stream_en = 1'b1;
    repeat (19) @(negedge clk);
    tests++; if (miss !== 1'b0) begin failed++; $display("FAIL miss_early: got %b want 0", miss); end
    @(negedge clk);
    tests++; if (miss !== 1'b1) begin failed++; $display("FAIL miss_set: got %b want 1", miss); end
    wait_conv(3, 100);
    stream_en = 1'b0;
    wait_adc_idle(40);
    tests++; if (conv_t[10'(cv_base + 2)] - conv_t[10'(cv_base + 1)] !== 20) begin
      failed++; $display("FAIL miss_interval: got %0d want 20", conv_t[10'(cv_base + 2)] - conv_t[10'(cv_base + 1)]);
    end
    n = conv_n - cv_base;
    for (int i = 0; i < n; i++) expect_sample(adc_hist[10'(cv_base + i)]);
    wait_rx(2 * n, 300);
    repeat (20) @(negedge clk);
    tests++; if (rx_n - rx_base !== 2 * n) begin failed++; $display("FAIL miss_byte_count: got %0d want %0d", rx_n - rx_base, 2 * n); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL miss_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
    tests++; if (miss !== 1'b1) begin failed++; $display("FAIL miss_sticky: got %b want 1", miss); end
  endtask

  task automatic test_overrun();
    int k;
    do_reset();
    uart_hold = 1'b1; stream_en = 1'b1;
    wait_conv(6, 200);
    stream_en = 1'b0;
    wait_adc_idle(40);
    repeat (2) @(negedge clk);
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    tests++; if (drop_count !== 8'd2) begin failed++; $display("FAIL overrun_drop_count: got %0d want 2", drop_count); end
    tests++; if (miss !== 1'b0) begin failed++; $display("FAIL overrun_miss: got %b want 0", miss); end
    for (int i = 0; i < 4; i++) expect_sample(adc_hist[10'(cv_base + i)]);
    uart_hold = 1'b0;
    wait_rx(8, 200);
    repeat (20) @(negedge clk);
    tests++; if (rx_n - rx_base !== 8) begin failed++; $display("FAIL overrun_byte_count: got %0d want 8", rx_n - rx_base); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL overrun_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
  endtask

  task automatic test_disable();
    int k, highs;
    do_reset();
    uart_hold = 1'b1; stream_en = 1'b1;
    wait_conv(3, 200);
    wait_enable(1'b0, 10);
    wait_enable(1'b1, 30);
    stream_en = 1'b0; uart_hold = 1'b0;
    wait_adc_idle(40);
    tests++; if (conv_n - cv_base !== 4) begin failed++; $display("FAIL disable_conversions: got %0d want 4", conv_n - cv_base); end
    for (int i = 0; i < 4; i++) expect_sample(adc_hist[10'(cv_base + i)]);
    wait_rx(8, 200);
    repeat (20) @(negedge clk);
    tests++; if (rx_n - rx_base !== 8) begin failed++; $display("FAIL disable_byte_count: got %0d want 8", rx_n - rx_base); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL disable_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_enable) highs++;
    end
    tests++; if (highs !== 0) begin failed++; $display("FAIL disable_adc_idle: got %0d enabled clks want 0", highs); end
    tests++; if (drop_count !== 8'd0) begin failed++; $display("FAIL disable_drop_count: got %0d want 0", drop_count); end
    tests++; if (te_double - td_base !== 0) begin failed++; $display("FAIL disable_tx_enable_width: got %0d long pulses want 0", te_double - td_base); end
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset();
    uart_lat = 40; stream_en = 1'b1;
    wait_rx(1, 100);
    repeat (25) @(negedge clk);
    rst_n = 1'b0; stream_en = 1'b0;
    @(negedge clk);
    tests++; if (adc_enable !== 1'b0) begin failed++; $display("FAIL midrst_adc_enable: got %b want 0", adc_enable); end
    tests++; if (tx_enable !== 1'b0) begin failed++; $display("FAIL midrst_tx_enable: got %b want 0", tx_enable); end
    tests++; if (tx_data !== 8'h00) begin failed++; $display("FAIL midrst_tx_data: got %h want 00", tx_data); end
    tests++; if (drop_count !== 8'h00) begin failed++; $display("FAIL midrst_drop_count: got %h want 00", drop_count); end
    rst_n = 1'b1; uart_lat = 4;
    rx_base = rx_n; cv_base = conv_n;
    repeat (40) @(negedge clk);
    tests++; if (rx_n - rx_base !== 0) begin failed++; $display("FAIL midrst_stale_tx: got %0d bytes want 0", rx_n - rx_base); end
    stream_en = 1'b1;
    wait_conv(1, 50);
    stream_en = 1'b0;
    expect_sample(adc_hist[10'(cv_base)]);
    wait_rx(2, 100);
    repeat (20) @(negedge clk);
    tests++; if (rx_n - rx_base !== 2) begin failed++; $display("FAIL midrst_byte_count: got %0d want 2", rx_n - rx_base); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL midrst_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k;
    do_reset();
    uart_hold = 1'b1; stream_en = 1'b1;
    wait_conv(4, 200);
    stall = 1'b1;
    wait_enable(1'b0, 10);
    wait_enable(1'b1, 30);
    stream_en = 1'b0;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    uart_hold = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (drop_count !== 8'd0) begin failed++; $display("FAIL b2b_drop_count: got %0d want 0", drop_count); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    for (int i = 0; i < 5; i++) expect_sample(adc_hist[10'(cv_base + i)]);
    wait_rx(10, 300);
    repeat (20) @(negedge clk);
    tests++; if (rx_n - rx_base !== 10) begin failed++; $display("FAIL b2b_byte_count: got %0d want 10", rx_n - rx_base); end
    k = rx_base;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      tests++; if (rx_hist[k[9:0]] !== e) begin failed++; $display("FAIL b2b_byte: got %h want %h", rx_hist[k[9:0]], e); end
      k++;
    end
    do_reset();
    uart_hold = 1'b1; stream_en = 1'b1;
    wait_conv(14, 300);
    repeat (3) @(negedge clk);
    tests++; if (drop_count !== 8'd10) begin failed++; $display("FAIL sat_drop_count_10: got %0d want 10", drop_count); end
    wait_conv(304, 4000);
    stream_en = 1'b0;
    wait_adc_idle(40);
    repeat (3) @(negedge clk);
    tests++; if (drop_count !== 8'hFF) begin failed++; $display("FAIL sat_drop_count: got %h want ff", drop_count); end
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL sat_overrun: got %b want 1", overrun); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_overrun();
    test_disable();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
